// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time byte-stream loader for the instruction memory.
// Frame: LEN_HI, LEN_LO (big-endian word count N), then 4*N bytes, MSB first.
// Holds the core (cpu_run=0) until the whole image is written.
// Optional macro IMEM_BOOT_CHECKSUM_EN: a trailing XOR checksum byte is
// required after the data bytes (also for N=0).
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_run,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           word_count
);

  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
`ifdef IMEM_BOOT_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t                state;
  logic [15:0]           len;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-9:0] shift;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  logic        xfer;
  logic [16:0] len_full;

  // Handshake and the length as it will be once LEN_LO is latched.
  always_comb begin
    xfer     = in_valid && in_ready;
    len_full = {1'b0, len[15:8], in_data};
  end

  // Loader FSM; in_ready is registered from the next state so no byte is
  // accepted once the image is complete or rejected.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_LEN_HI;
      len        <= '0;
      byte_idx   <= '0;
      shift      <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum       <= '0;
`endif
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_LEN_HI: begin
          in_ready <= 1'b1;
          if (xfer) begin
            len[15:8] <= in_data;
            state     <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          in_ready <= 1'b1;
          if (xfer) begin
            len[7:0] <= in_data;
            byte_idx <= '0;
            if (len_full == 17'd0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state    <= ST_DONE;
              in_ready <= 1'b0;
`endif
            end else if (len_full > MAX_LEN) begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            shift    <= {shift[DATA_WIDTH-17:0], in_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {shift, in_data};
              imem_addr  <= word_count[ADDR_WIDTH-1:0];
              word_count <= word_count + 16'd1;
              if (word_count + 16'd1 == len) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                state <= ST_CHECK;
`else
                state    <= ST_DONE;
                in_ready <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            state    <= (in_data == csum) ? ST_DONE : ST_ERROR;
          end
        end
`endif
        // Run is raised one cycle after entering DONE, i.e. after the last write.
        ST_DONE: begin
          in_ready  <= 1'b0;
          load_done <= 1'b1;
          cpu_run   <= 1'b1;
        end
        ST_ERROR: begin
          in_ready   <= 1'b0;
          load_error <= 1'b1;
          cpu_run    <= 1'b0;
        end
        default: begin
          state    <= ST_ERROR;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (ADDR_WIDTH=8).
module tb_imem_boot_loader;

  localparam int unsigned AW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic          load_done;
  logic          load_error;
  logic [15:0]   word_count;

  imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_error (load_error),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Write-port monitor.
  int          wr_n = 0;
  logic [7:0]  wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          wr_cyc  [0:1023];
  logic        wr_run  [0:1023];

  always @(negedge clock) begin
    if (imem_we) begin
      if (wr_n < 1024) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
        wr_cyc[wr_n]  = cyc;
        wr_run[wr_n]  = cpu_run;
      end
      wr_n++;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int acc [0:1199];
  int nb = 0;
  int base = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one byte and wait (bounded) for it to be accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock);
      if (in_ready) begin
        if (nb < 1200) acc[nb] = cyc + 1;
        nb++;
        ok = 1'b1;
        @(posedge clock);
        #1;
      end
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'hFF;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset_n  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    nb      = 0;
    base    = wr_n;
  endtask

  task automatic send_test_stream(input bit gap);
    logic [7:0] s [0:9];
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    nb = 0;
    for (int i = 0; i < 10; i++) send_byte(s[i], gap);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(8'h03, gap);
`endif
  endtask

  task automatic check_two_words(input string p);
    chk({p, "_nwr"}, 32'(wr_n - base), 32'd2);
    chk({p, "_addr0"}, 32'(wr_addr[base]), 32'd0);
    chk({p, "_data0"}, wr_data[base], 32'h20080005);
    chk({p, "_addr1"}, 32'(wr_addr[base+1]), 32'd1);
    chk({p, "_data1"}, wr_data[base+1], 32'h20090007);
    chk({p, "_lat0"}, 32'(wr_cyc[base]), 32'(acc[5]));
    chk({p, "_lat1"}, 32'(wr_cyc[base+1]), 32'(acc[9]));
    chk({p, "_run_at_wr"}, 32'(wr_run[base+1]), 32'd0);
    chk({p, "_cpu_run"}, 32'(cpu_run), 32'd1);
    chk({p, "_done"}, 32'(load_done), 32'd1);
    chk({p, "_err"}, 32'(load_error), 32'd0);
    chk({p, "_wc"}, 32'(word_count), 32'd2);
    chk({p, "_ready"}, 32'(in_ready), 32'd0);
    chk({p, "_we"}, 32'(imem_we), 32'd0);
    chk({p, "_addr_hold"}, 32'(imem_addr), 32'd1);
    chk({p, "_data_hold"}, imem_wdata, 32'h20090007);
  endtask

  initial begin
    // Reset values while reset is held.
    #12;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_run", 32'(cpu_run), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    do_reset();

    // Two words, valid held high; then a byte presented after DONE is ignored.
    send_test_stream(1'b0);
    in_data = 8'hAA;
    in_valid = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    idle(2);
    check_two_words("b2b");
    chk("b2b_thru", 32'(acc[9] - acc[0]), 32'd9);

    // Same stream with in_valid toggling.
    do_reset();
    send_test_stream(1'b1);
    idle(3);
    check_two_words("gap");

    // Over-length frame 0x0101.
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    idle(4);
    chk("ovf_err", 32'(load_error), 32'd1);
    chk("ovf_ready", 32'(in_ready), 32'd0);
    chk("ovf_run", 32'(cpu_run), 32'd0);
    chk("ovf_done", 32'(load_done), 32'd0);
    chk("ovf_nwr", 32'(wr_n - base), 32'd0);

    // Zero-length frame.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    idle(4);
    chk("zero_done", 32'(load_done), 32'd1);
    chk("zero_run", 32'(cpu_run), 32'd1);
    chk("zero_err", 32'(load_error), 32'd0);
    chk("zero_nwr", 32'(wr_n - base), 32'd0);

    // Maximum legal length, N = 256; word i = {4{i}} so the checksum is 0.
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++) send_byte(8'(i), 1'b0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    idle(4);
    chk("max_nwr", 32'(wr_n - base), 32'd256);
    for (int i = 0; i < 256; i++) begin
      chk("max_addr", 32'(wr_addr[base+i]), 32'(i));
      chk("max_data", wr_data[base+i], {4{8'(i)}});
    end
    chk("max_wc", 32'(word_count), 32'd256);
    chk("max_done", 32'(load_done), 32'd1);
    chk("max_err", 32'(load_error), 32'd0);

    // Reset after 3 bytes of word 1, then a fresh 1-word frame.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h09, 1'b0);
    send_byte(8'h00, 1'b0);
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort_wc", 32'(word_count), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_addr", 32'(imem_addr), 32'd0);
    chk("abort_wdata", imem_wdata, 32'd0);
    chk("abort_we", 32'(imem_we), 32'd0);
    chk("abort_run", 32'(cpu_run), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    nb = 0;
    base = wr_n;
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(8'h22, 1'b0);
`endif
    idle(4);
    chk("fresh_nwr", 32'(wr_n - base), 32'd1);
    chk("fresh_addr", 32'(wr_addr[base]), 32'd0);
    chk("fresh_data", wr_data[base], 32'hDEADBEEF);
    chk("fresh_wc", 32'(word_count), 32'd1);
    chk("fresh_done", 32'(load_done), 32'd1);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum good and bad on 00 01 | 12 34 56 78.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h08, 1'b0);
    idle(4);
    chk("cs_ok_done", 32'(load_done), 32'd1);
    chk("cs_ok_run", 32'(cpu_run), 32'd1);
    chk("cs_ok_err", 32'(load_error), 32'd0);

    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h09, 1'b0);
    idle(4);
    chk("cs_bad_err", 32'(load_error), 32'd1);
    chk("cs_bad_run", 32'(cpu_run), 32'd0);
    chk("cs_bad_done", 32'(load_done), 32'd0);
    chk("cs_bad_nwr", 32'(wr_n - base), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream boot stage for the single-cycle MIPS core.
- Receives a byte stream over a valid/ready handshake, packs the bytes into 32-bit big-endian instruction words, and writes them into the instruction memory.
- Holds the core stalled until the image is complete, so programs load at run time instead of from simulation-only memory init.
- Sits between an external byte source (UART receiver or testbench driver) and the instruction memory write port / core run enable.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory (depth = 2**ADDR_WIDTH words).
- DATA_WIDTH, 32, instruction word width; fixed at 32, 4 bytes per word.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- imem_we  output  1  instruction memory write strobe, one-cycle pulse per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_run  output  1  high when the core may execute; low holds the core (PC and regfile write stalled).
- load_done  output  1  sticky, image loaded successfully.
- load_error  output  1  sticky, length overflow (or checksum fail, see option).
- word_count  output  16  words written so far.

Behaviour:
- Reset (asynchronous, reset_n low):
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_run=0, load_done=0, load_error=0, word_count=0.
  - State = LEN_HI.
  - Asserting reset mid-load aborts the load; the partially written memory is not cleared.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, MSB of each word first.
- States:
  - LEN_HI: in_ready=1; on transfer, latch len[15:8] -> LEN_LO.
  - LEN_LO: in_ready=1; on transfer, latch len[7:0]. If the full length is 0 -> DONE. Else if len > 2**ADDR_WIDTH -> ERROR. Else -> DATA with byte index 0.
  - DATA: in_ready=1. Each transfer shifts the byte into the assembly register.
    - On the 4th byte, in the next cycle: imem_we=1, imem_wdata=assembled word, imem_addr=word_count.
    - word_count increments in that same cycle.
    - Latency from 4th-byte acceptance to imem_we is exactly 1 cycle.
    - After word N is written -> DONE (or CHECK if CHECKSUM_EN).
  - DONE: in_ready=0, load_done=1, cpu_run=1 from the cycle after the last write; the core never sees a half-written image. Stays here until reset.
  - ERROR: in_ready=0, load_error=1, cpu_run=0 until reset.
- Write pulse:
  - imem_we is a single-cycle pulse.
  - imem_addr/imem_wdata hold their last value while imem_we=0.
- in_valid deasserted mid-word:
  - Assembly pauses; no timeout.
  - Partial bytes are retained and the byte index does not reset.
- Bytes presented while in_ready=0 are not consumed; the source must hold them.
- Address wrap cannot occur: N is bounded at 2**ADDR_WIDTH, so the last address is 2**ADDR_WIDTH-1.
- N == 2**ADDR_WIDTH is legal.
- Back-to-back transfers: one byte per cycle is sustained; a word write overlaps the first byte of the next word.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- When defined:
  - After the last data byte, state CHECK expects one extra byte equal to the XOR of all 4*N data bytes.
  - Match -> DONE.
  - Mismatch -> ERROR (load_error=1, cpu_run stays 0).
  - For N=0, the checksum byte 0x00 is still expected; LEN_LO goes to CHECK.
- When undefined:
  - No CHECK state and no XOR accumulator.
  - DATA -> DONE directly.

Test Plan:
- Reset then stream 00 02 | 20 08 00 05 | 20 09 00 07 with in_valid held high -> imem_we pulses at addr 0 with 0x20080005, then addr 1 with 0x20090007. Each pulse is one cycle after the 4th byte. cpu_run=1, load_done=1, word_count=2.
- Same stream with in_valid toggled every other cycle -> identical writes and final state; no byte lost or duplicated.
- Length 0x0101 with ADDR_WIDTH=8 -> ERROR after LEN_LO. load_error=1, in_ready=0, cpu_run=0, no imem_we pulse.
- Length 0x0000 -> load_done=1 and cpu_run=1 with zero writes (without the option); with the option, this happens after checksum byte 0x00.
- Pull reset_n low after 3 of 4 bytes of word 1 -> all outputs return to reset values immediately. A fresh 1-word frame then writes addr 0 correctly.
- IMEM_BOOT_CHECKSUM_EN defined, 1-word frame 00 01 | 12 34 56 78:
  - Checksum byte 0x08 -> DONE, cpu_run=1.
  - Checksum byte 0x09 -> load_error=1, cpu_run=0.
